// File: rtl/fpnew_hub_div_multi.sv
// HUB-format division unit: NumUnits iterative dividers fed round-robin,
// results retired strictly in issue order, with flush, tag passthrough
// and IEEE-style status flags.

// Iterative HUB divider: operands carry an implicit trailing 1 below the
// stored mantissa, and the quotient is truncated so its own implicit
// trailing 1 keeps it within half an ulp of the true value.
module FPHUB_divider #(
  parameter int M = 10,
  parameter int E = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [E+M:0] x_i,
  input  logic [E+M:0] d_i,
  output logic [E+M:0] res_o,
  output logic         finish_o,
  output logic         computing_o
);
  localparam int Bias   = (1 << (E - 1)) - 1;
  localparam int ExpMax = (1 << E) - 1;
  localparam int CntW   = $clog2(M + 2);

  logic [M+1:0]   w_mx, w_md;
  logic           w_xLess, w_sign;
  logic [M+2:0]   w_rem0;
  logic [E+1:0]   w_exp0;
  logic           w_xZero, w_xInf, w_dZero, w_dInf, w_special;
  logic [E+M:0]   w_specRes, w_final;
  logic           w_expBig, w_expLow;

  logic           r_busy, r_finish, r_sign, r_special;
  logic [CntW-1:0] r_cnt;
  logic [M+2:0]   r_rem;
  logic [M+1:0]   r_md;
  logic [M:0]     r_q;
  logic [E+1:0]   r_exp;
  logic [E+M:0]   r_specRes, r_res;
  logic           w_unused;

  assign w_mx    = {1'b1, x_i[M-1:0], 1'b1};
  assign w_md    = {1'b1, d_i[M-1:0], 1'b1};
  assign w_xLess = w_mx < w_md;
  assign w_rem0  = w_xLess ? {w_mx, 1'b0} : {1'b0, w_mx};
  assign w_exp0  = {2'b00, x_i[E+M-1:M]} - {2'b00, d_i[E+M-1:M]}
                 + (E+2)'(Bias) - (E+2)'(w_xLess);
  assign w_sign  = x_i[E+M] ^ d_i[E+M];

  assign w_xZero   = x_i[E+M-1:0] == '0;
  assign w_xInf    = &x_i[E+M-1:0];
  assign w_dZero   = d_i[E+M-1:0] == '0;
  assign w_dInf    = &d_i[E+M-1:0];
  assign w_special = w_xZero | w_xInf | w_dZero | w_dInf;
  assign w_specRes = ((w_xZero & w_dZero) | (w_xInf & w_dInf)) ? {w_sign, {(E+M){1'b0}}} :
                     (w_xZero | w_dInf)                         ? {w_sign, {(E+M){1'b0}}} :
                                                                  {w_sign, {(E+M){1'b1}}};

  assign w_expBig = !r_exp[E+1] && (r_exp[E:0] >= (E+1)'(ExpMax));
  assign w_expLow = r_exp[E+1] || (r_exp == '0);
  assign w_final  = r_special ? r_specRes :
                    w_expBig  ? {r_sign, {(E+M){1'b1}}} :
                    w_expLow  ? {r_sign, {(E+M){1'b0}}} :
                                {r_sign, r_exp[E-1:0], r_q[M-1:0]};

  assign res_o       = r_res;
  assign finish_o    = r_finish;
  assign computing_o = r_busy;
  assign w_unused    = r_q[M];

  // Load on start, one restoring-division step per cycle, then pack result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_sign    <= 1'b0;
      r_special <= 1'b0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_md      <= '0;
      r_q       <= '0;
      r_exp     <= '0;
      r_specRes <= '0;
      r_res     <= '0;
    end else begin
      r_finish <= 1'b0;
      if (start_i) begin
        r_busy    <= 1'b1;
        r_cnt     <= w_special ? '0 : CntW'(M + 1);
        r_rem     <= w_rem0;
        r_md      <= w_md;
        r_q       <= '0;
        r_exp     <= w_exp0;
        r_sign    <= w_sign;
        r_special <= w_special;
        r_specRes <= w_specRes;
      end else if (r_busy) begin
        if (r_cnt != '0) begin
          if (r_rem >= {1'b0, r_md}) begin
            r_rem <= (r_rem - {1'b0, r_md}) << 1;
            r_q   <= {r_q[M-1:0], 1'b1};
          end else begin
            r_rem <= r_rem << 1;
            r_q   <= {r_q[M-1:0], 1'b0};
          end
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_busy   <= 1'b0;
          r_finish <= 1'b1;
          r_res    <= w_final;
        end
      end
    end
  end
endmodule

module fpnew_hub_div_multi #(
  parameter int WIDTH    = 16,
  parameter int M        = 10,
  parameter int E        = 5,
  parameter int NumUnits = 2,
  parameter int TagWidth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [2:0][WIDTH-1:0]    operands_i,
  input  logic [3:0]               op_i,
  input  logic                     op_mod_i,
  input  logic [TagWidth-1:0]      tag_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         result_o,
  output logic [4:0]               status_o,
  output logic [TagWidth-1:0]      tag_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     busy_o
);
  localparam logic [3:0] OpDiv = 4'd4;
  localparam int PtrW = (NumUnits > 1) ? $clog2(NumUnits) : 1;

  typedef enum logic [1:0] {SlotFree, SlotRun, SlotDone, SlotDrain} slotState_e;

  slotState_e            r_state     [NumUnits];
  slotState_e            w_nextState [NumUnits];
  logic [WIDTH-1:0]      r_slotRes    [NumUnits];
  logic [4:0]            r_slotStatus [NumUnits];
  logic [TagWidth-1:0]   r_slotTag    [NumUnits];
  logic [3:0]            r_slotClass  [NumUnits];
  logic [WIDTH-1:0]      w_res        [NumUnits];
  logic [4:0]            w_finStatus  [NumUnits];
  logic [NumUnits-1:0]   w_start, w_finish, w_comp;
  logic [PtrW-1:0]       r_issuePtr, r_retirePtr;
  logic                  w_isDiv, w_accept, w_issue, w_retire, w_anyOcc;
  logic [3:0]            w_inClass;
  logic                  w_unused;

  assign w_isDiv   = op_i == OpDiv;
  assign w_inClass = {operands_i[0][E+M-1:0] == '0, &operands_i[0][E+M-1:0],
                      operands_i[1][E+M-1:0] == '0, &operands_i[1][E+M-1:0]};
  assign in_ready_o  = r_state[r_issuePtr] == SlotFree;
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_issue     = w_accept & !flush_i;
  assign out_valid_o = (r_state[r_retirePtr] == SlotDone) & !flush_i;
  assign w_retire    = out_valid_o & out_ready_i;
  assign result_o    = r_slotRes[r_retirePtr];
  assign status_o    = r_slotStatus[r_retirePtr];
  assign tag_o       = r_slotTag[r_retirePtr];
  assign busy_o      = w_anyOcc | (|w_comp);
  assign w_unused    = ^{op_mod_i, operands_i[2]};

  for (genvar g = 0; g < NumUnits; g++) begin : gUnit
    logic w_resZero, w_resInf;
    assign w_start[g] = w_issue & w_isDiv & (r_issuePtr == PtrW'(g));
    assign w_resZero  = w_res[g][E+M-1:0] == '0;
    assign w_resInf   = &w_res[g][E+M-1:0];
    assign w_finStatus[g] = {
      (r_slotClass[g][3] & r_slotClass[g][1]) | (r_slotClass[g][2] & r_slotClass[g][0]),
      r_slotClass[g][1] & !r_slotClass[g][3],
      w_resInf & !r_slotClass[g][2] & !r_slotClass[g][0],
      w_resZero & !r_slotClass[g][3] & !r_slotClass[g][0],
      1'b0};

    FPHUB_divider #(.M(M), .E(E)) uDiv (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (w_start[g]),
      .x_i         (operands_i[0]),
      .d_i         (operands_i[1]),
      .res_o       (w_res[g]),
      .finish_o    (w_finish[g]),
      .computing_o (w_comp[g])
    );
  end

  // Per-slot lifecycle: issue, divider finish, retire, and flush draining.
  always_comb begin
    for (int i = 0; i < NumUnits; i++) begin
      w_nextState[i] = r_state[i];
      case (r_state[i])
        SlotFree:
          if (w_issue && r_issuePtr == PtrW'(i)) w_nextState[i] = w_isDiv ? SlotRun : SlotDone;
        SlotRun:
          if (flush_i) w_nextState[i] = SlotDrain;
          else if (w_finish[i]) w_nextState[i] = SlotDone;
        SlotDone:
          if (flush_i) w_nextState[i] = SlotDrain;
          else if (w_retire && r_retirePtr == PtrW'(i)) w_nextState[i] = SlotFree;
        SlotDrain:
          if (!w_comp[i]) w_nextState[i] = SlotFree;
        default: w_nextState[i] = SlotFree;
      endcase
    end
  end

  // Any slot holding or waiting on work keeps the unit busy.
  always_comb begin
    w_anyOcc = 1'b0;
    for (int i = 0; i < NumUnits; i++) begin
      if (r_state[i] != SlotFree) w_anyOcc = 1'b1;
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumUnits; i++) r_state[i] <= SlotFree;
    end else begin
      for (int i = 0; i < NumUnits; i++) r_state[i] <= w_nextState[i];
    end
  end

  // Slot payload: tag and operand class at issue, quotient and flags at finish.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumUnits; i++) begin
        r_slotRes[i]    <= '0;
        r_slotStatus[i] <= '0;
        r_slotTag[i]    <= '0;
        r_slotClass[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NumUnits; i++) begin
        if (w_issue && r_issuePtr == PtrW'(i)) begin
          r_slotTag[i]   <= tag_i;
          r_slotClass[i] <= w_inClass;
          if (!w_isDiv) begin
            r_slotRes[i]    <= '0;
            r_slotStatus[i] <= 5'b10000;
          end
        end else if (w_finish[i] && r_state[i] == SlotRun && !flush_i) begin
          r_slotRes[i]    <= w_res[i];
          r_slotStatus[i] <= w_finStatus[i];
        end
      end
    end
  end

  // Round-robin issue and retire pointers; flush restarts both at slot 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_issuePtr  <= '0;
      r_retirePtr <= '0;
    end else if (flush_i) begin
      r_issuePtr  <= '0;
      r_retirePtr <= '0;
    end else begin
      if (w_issue)
        r_issuePtr <= (r_issuePtr == PtrW'(NumUnits - 1)) ? '0 : r_issuePtr + 1'b1;
      if (w_retire)
        r_retirePtr <= (r_retirePtr == PtrW'(NumUnits - 1)) ? '0 : r_retirePtr + 1'b1;
    end
  end
endmodule

// File: tb/tb_fpnew_hub_div_multi.sv
// Directed bench for the multi-unit HUB divider: ordering, back-pressure,
// special-value flags, non-DIV ops, flush and asynchronous reset.
module tb_fpnew_hub_div_multi;
  localparam logic [3:0] OpDiv = 4'd4;
  localparam logic [3:0] OpAdd = 4'd2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [2:0][15:0]  operands_i;
  logic [3:0]        op_i;
  logic              op_mod_i;
  logic [3:0]        tag_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic              flush_i;
  logic [15:0]       result_o;
  logic [4:0]        status_o;
  logic [3:0]        tag_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic              busy_o;

  int vectorCount = 0;
  int missCount   = 0;

  logic [15:0] t3X   [5] = '{16'h3C00, 16'h3C00, 16'h0000, 16'h7BFF, 16'h0400};
  logic [15:0] t3D   [5] = '{16'h0000, 16'h8000, 16'h0000, 16'h0400, 16'h7800};
  logic [15:0] t3Res [5] = '{16'h7FFF, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0000};
  logic [4:0]  t3St  [5] = '{5'b01100, 5'b01100, 5'b10000, 5'b00100, 5'b00010};

  fpnew_hub_div_multi dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .operands_i  (operands_i),
    .op_i        (op_i),
    .op_mod_i    (op_mod_i),
    .tag_i       (tag_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .status_o    (status_o),
    .tag_o       (tag_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  // Free-running 100 MHz clock.
  always #5 clk_i = ~clk_i;

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one op at a negedge, hold it through one accepting posedge.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] d,
                               input logic [3:0] op, input logic [3:0] tg);
    int n = 0;
    while (!in_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("issueReady", 32'(in_ready_o), 32'd1);
    operands_i[0] = x;
    operands_i[1] = d;
    op_i          = op;
    tag_i         = tg;
    in_valid_i    = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  // Wait (bounded) for a result and compare quotient, flags and tag.
  task automatic expectResult(input string name, input logic [15:0] res,
                              input logic [4:0] st, input logic [3:0] tg);
    int n = 0;
    while (!out_valid_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({name, "_valid"},  32'(out_valid_o), 32'd1);
    checkOutput({name, "_result"}, 32'(result_o),    32'(res));
    checkOutput({name, "_status"}, 32'(status_o),    32'(st));
    checkOutput({name, "_tag"},    32'(tag_o),       32'(tg));
  endtask

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int validSeen;
    rst_ni      = 1'b0;
    operands_i  = '0;
    op_i        = OpDiv;
    op_mod_i    = 1'b0;
    tag_i       = '0;
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    #22;
    checkOutput("rst_inReady",  32'(in_ready_o),  32'd1);
    checkOutput("rst_outValid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_result",   32'(result_o),    32'd0);
    checkOutput("rst_status",   32'(status_o),    32'd0);
    checkOutput("rst_tag",      32'(tag_o),       32'd0);
    checkOutput("rst_busy",     32'(busy_o),      32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single division, then the unit goes idle.
    applyStimulus(16'h3C00, 16'h4000, OpDiv, 4'd5);
    expectResult("t1", 16'h3800, 5'b00000, 4'd5);
    @(negedge clk_i);
    checkOutput("t1_validDrop", 32'(out_valid_o), 32'd0);
    checkOutput("t1_busyDrop",  32'(busy_o),      32'd0);
    applyStimulus(16'h3E00, 16'h3C00, OpDiv, 4'd6);
    expectResult("t1b", 16'h3DFF, 5'b00000, 4'd6);
    @(negedge clk_i);
    applyStimulus(16'hC000, 16'h4000, OpDiv, 4'd7);
    expectResult("t1c", 16'hBC00, 5'b00000, 4'd7);
    @(negedge clk_i);

    // Two ops under back-pressure retire in order and hold stable.
    out_ready_i = 1'b0;
    applyStimulus(16'h3C00, 16'h4000, OpDiv, 4'd1);
    applyStimulus(16'h3E00, 16'h3C00, OpDiv, 4'd2);
    checkOutput("t2_readyLow", 32'(in_ready_o), 32'd0);
    repeat (30) @(negedge clk_i);
    expectResult("t2_stallA", 16'h3800, 5'b00000, 4'd1);
    repeat (10) @(negedge clk_i);
    expectResult("t2_stallB", 16'h3800, 5'b00000, 4'd1);
    checkOutput("t2_readyFull", 32'(in_ready_o), 32'd0);
    out_ready_i = 1'b1;
    @(negedge clk_i);
    expectResult("t2_second", 16'h3DFF, 5'b00000, 4'd2);
    @(negedge clk_i);
    checkOutput("t2_drained", 32'(out_valid_o), 32'd0);

    // Special operands and exponent range limits.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(t3X[i], t3D[i], OpDiv, 4'(i + 8));
      expectResult($sformatf("t3_%0d", i), t3Res[i], t3St[i], 4'(i + 8));
      @(negedge clk_i);
    end

    // Non-DIV op completes next cycle without touching a divider.
    applyStimulus(16'h3C00, 16'h4000, OpAdd, 4'd9);
    checkOutput("t4_validNext", 32'(out_valid_o), 32'd1);
    expectResult("t4", 16'h0000, 5'b10000, 4'd9);
    @(negedge clk_i);
    checkOutput("t4_busy", 32'(busy_o), 32'd0);

    // Flush with two divisions in flight.
    applyStimulus(16'h3C00, 16'h4000, OpDiv, 4'd3);
    applyStimulus(16'h3E00, 16'h3C00, OpDiv, 4'd4);
    repeat (2) @(negedge clk_i);
    flush_i = 1'b1;
    checkOutput("t5_flushValid", 32'(out_valid_o), 32'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    checkOutput("t5_readyDrain", 32'(in_ready_o), 32'd0);
    checkOutput("t5_busyDrain",  32'(busy_o),     32'd1);
    validSeen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid_o) validSeen++;
      @(negedge clk_i);
    end
    checkOutput("t5_noRetire", 32'(validSeen),  32'd0);
    checkOutput("t5_readyBack", 32'(in_ready_o), 32'd1);
    checkOutput("t5_idle",     32'(busy_o),      32'd0);
    applyStimulus(16'h3E00, 16'h3C00, OpDiv, 4'd7);
    expectResult("t5_after", 16'h3DFF, 5'b00000, 4'd7);
    @(negedge clk_i);

    // Asynchronous reset while one result waits and another is computing.
    out_ready_i = 1'b0;
    applyStimulus(16'hC000, 16'h4000, OpDiv, 4'd5);
    applyStimulus(16'h3C00, 16'h4000, OpDiv, 4'd6);
    expectResult("t6_pre", 16'hBC00, 5'b00000, 4'd5);
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_inReady",  32'(in_ready_o),  32'd1);
    checkOutput("t6_outValid", 32'(out_valid_o), 32'd0);
    checkOutput("t6_result",   32'(result_o),    32'd0);
    checkOutput("t6_status",   32'(status_o),    32'd0);
    checkOutput("t6_tag",      32'(tag_o),       32'd0);
    checkOutput("t6_busy",     32'(busy_o),      32'd0);
    @(negedge clk_i);
    rst_ni      = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    applyStimulus(16'h3E00, 16'h3C00, OpDiv, 4'd10);
    expectResult("t6_after", 16'h3DFF, 5'b00000, 4'd10);
    @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
